// File: rtl/line_decoder_pkg.sv
// Shared widths and the reversed one-hot decode used by the line decoder.
// Select index n lights output bit (OUT_W-1-n), so n=0 drives the MSB.
package line_decoder_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    // Reversed mapping: select 0 lights the MSB; disabled gives all zeros.
    function automatic logic [OUT_W-1:0] decode_rev(input logic en, input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] one;
        one = OUT_W'(1);
        return en ? (one << (SEL_W'(OUT_W-1) - sel)) : '0;
    endfunction

endpackage

// File: rtl/line_decoder_if.sv
// Select/enable inputs and decoded outputs of the line decoder.
// The master drives the select side; the slave is the decoder itself.
interface line_decoder_if;
    import line_decoder_pkg::*;

    logic             Enable;
    logic             A;
    logic             B;
    logic             C;
    logic [OUT_W-1:0] F;
    logic [OUT_W-1:0] F_q;
    logic             en_q;

    modport master (
        output Enable, A, B, C,
        input  F, F_q, en_q
    );

    modport slave (
        input  Enable, A, B, C,
        output F, F_q, en_q
    );

endinterface

// File: rtl/line_decoder_reg.sv
// Output register for the decoder: holds the decoded lines plus the enable
// that qualifies them, cleared asynchronously by rst_n.
module line_decoder_reg
    import line_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OUT_W-1:0] d_f,
    input  logic             d_en,
    output logic [OUT_W-1:0] q_f,
    output logic             q_en
);

    // Loads every edge; there is no hold, so q always trails d by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_f  <= '0;
            q_en <= 1'b0;
        end else begin
            q_f  <= d_f;
            q_en <= d_en;
        end
    end

endmodule

// File: rtl/line_decoder.sv
// Enable-gated 3-to-8 reversed line decoder with a combinational output for
// same-cycle consumers and a registered copy for high fan-out destinations.
module line_decoder
    import line_decoder_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    line_decoder_if.slave bus
);

    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] f;
    logic [OUT_W-1:0] f_q;
    logic             en_q;

    assign sel = {bus.A, bus.B, bus.C};

    // F ignores clk and rst_n so it keeps tracking the inputs through a reset.
    assign f = decode_rev(bus.Enable, sel);

    line_decoder_reg u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_f   (f),
        .d_en  (bus.Enable),
        .q_f   (f_q),
        .q_en  (en_q)
    );

    assign bus.F    = f;
    assign bus.F_q  = f_q;
    assign bus.en_q = en_q;

endmodule

// File: tb/tb_line_decoder.sv
// Directed and randomised checks of the line decoder: decode table, enable
// gating, asynchronous reset, one-cycle register latency.
module tb_line_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic clkRun = 1'b0;

    int checks   = 0;
    int failures = 0;

    line_decoder_if bus ();

    line_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock can be parked low to observe behaviour with no edges at all.
    initial forever #5 clk = clkRun ? ~clk : 1'b0;

    task automatic applyStimulus(input logic en, input logic [2:0] n);
        bus.Enable = en;
        {bus.A, bus.B, bus.C} = n;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [7:0] decTable [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] expF;
    logic       expEn;
    logic       rEn;
    logic [2:0] rSel;

    initial begin
        applyStimulus(1'b0, 3'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_F_q", bus.F_q, 8'h00);
        checkOutput("reset_en_q", {7'b0, bus.en_q}, 8'h00);

        applyStimulus(1'b1, 3'd7);
        #5;
        checkOutput("noclk_n7", bus.F, 8'h01);
        checkOutput("noclk_F_q_held", bus.F_q, 8'h00);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i));
            #1;
            checkOutput($sformatf("en_sweep_%0d", i), bus.F, decTable[i]);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'(i));
            #1;
            checkOutput($sformatf("dis_sweep_%0d", i), bus.F, 8'h00);
        end

        rst_n = 1'b1;
        #1;
        clkRun = 1'b1;
        applyStimulus(1'b1, 3'd5);
        @(posedge clk);
        #1;
        checkOutput("clk_k_F_q", bus.F_q, 8'h04);
        checkOutput("clk_k_en_q", {7'b0, bus.en_q}, 8'h01);
        applyStimulus(1'b1, 3'd1);
        #1;
        checkOutput("clk_k_F_follows", bus.F, 8'h40);
        checkOutput("clk_k_F_q_holds", bus.F_q, 8'h04);
        @(posedge clk);
        #1;
        checkOutput("clk_k1_F_q", bus.F_q, 8'h40);

        applyStimulus(1'b1, 3'd5);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_F_q", bus.F_q, 8'h04);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_F_q", bus.F_q, 8'h00);
        checkOutput("midreset_en_q", {7'b0, bus.en_q}, 8'h00);
        checkOutput("midreset_F_live", bus.F, 8'h04);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd2);
        @(posedge clk);
        #1;
        checkOutput("release_F_q", bus.F_q, 8'h20);
        checkOutput("release_en_q", {7'b0, bus.en_q}, 8'h01);

        for (int i = 0; i < 200; i++) begin
            rEn  = 1'($urandom_range(0, 1));
            rSel = 3'($urandom_range(0, 7));
            applyStimulus(rEn, rSel);
            expF  = rEn ? (8'h80 >> rSel) : 8'h00;
            expEn = rEn;
            #1;
            checkOutput("rand_F", bus.F, expF);
            checkOutput("rand_onehot0", {7'b0, $onehot0(bus.F)}, 8'h01);
            @(posedge clk);
            #1;
            checkOutput("rand_F_q", bus.F_q, expF);
            checkOutput("rand_en_q", {7'b0, bus.en_q}, {7'b0, expEn});
        end

        clkRun = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
